// File: rtl/sdram_port_arbiter.sv
// Three-way arbiter in front of the SDRAM controller's toggle-handshake byte channel.
// VID has priority (bounded by VID_MAX while others wait); CPU and DMA alternate.
module sdram_port_arbiter #(
  parameter int AW      = 21,
  parameter int VID_MAX = 4,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_ack,
  output logic [7:0]    vid_dout,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_din,
  output logic          cpu_ack,
  output logic [7:0]    cpu_dout,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [7:0]    dma_din,
  output logic          dma_ack,
  output logic [7:0]    dma_dout,
  output logic          mem_req,
  input  logic          mem_ack,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_din,
  input  logic [7:0]    mem_dout,
  output logic          busy,
  output logic          err
);

  localparam int CW = (VID_MAX < 1) ? 1 : $clog2(VID_MAX + 1);
  localparam logic [CW-1:0] VID_LIMIT = CW'(VID_MAX);
  localparam logic [7:0]    TMO_LIMIT = 8'(TIMEOUT);

  typedef enum logic [2:0] {SYNC, IDLE, ISSUE, WAIT, DONE} state_t;
  typedef enum logic [1:0] {G_VID, G_CPU, G_DMA} grant_t;

  state_t          state_q, state_d;
  grant_t          grant_q, grant_d;
  logic            rr_q, rr_d;
  logic [CW-1:0]   vid_cnt_q, vid_cnt_d;
  logic [7:0]      tmo_q, tmo_d;
  logic            err_q, err_d;
  logic            busy_q;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]      mem_din_q, mem_din_d;
  logic [7:0]      vid_dout_q, vid_dout_d;
  logic [7:0]      cpu_dout_q, cpu_dout_d;
  logic [7:0]      dma_dout_q, dma_dout_d;

  logic other_pending;
  logic vid_blocked;
  logic mem_done;

  assign other_pending = cpu_req | dma_req;
  assign vid_blocked   = (vid_cnt_q == VID_LIMIT) && other_pending;
  assign mem_done      = (mem_ack == mem_req_q);

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_d       = rr_q;
    vid_cnt_d  = vid_cnt_q;
    tmo_d      = tmo_q;
    err_d      = err_q;
    mem_req_d  = mem_req_q;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    vid_dout_d = vid_dout_q;
    cpu_dout_d = cpu_dout_q;
    dma_dout_d = dma_dout_q;

    case (state_q)
      // Waits out any toggle left outstanding by a reset mid-transaction.
      SYNC: begin
        if (mem_done) state_d = IDLE;
      end
      IDLE: begin
        if (vid_req && !vid_blocked) begin
          grant_d    = G_VID;
          mem_we_d   = 1'b0;
          mem_addr_d = vid_addr;
          mem_din_d  = 8'h00;
          state_d    = ISSUE;
        end else if (cpu_req && (!dma_req || !rr_q)) begin
          grant_d    = G_CPU;
          mem_we_d   = cpu_we;
          mem_addr_d = cpu_addr;
          mem_din_d  = cpu_din;
          state_d    = ISSUE;
        end else if (dma_req) begin
          grant_d    = G_DMA;
          mem_we_d   = dma_we;
          mem_addr_d = dma_addr;
          mem_din_d  = dma_din;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        mem_req_d = ~mem_req_q;
        tmo_d     = 8'h00;
        state_d   = WAIT;
      end
      WAIT: begin
        if (mem_done) begin
          if (!mem_we_q) begin
            case (grant_q)
              G_VID:   vid_dout_d = mem_dout;
              G_CPU:   cpu_dout_d = mem_dout;
              default: dma_dout_d = mem_dout;
            endcase
          end
          state_d = DONE;
        end else if (tmo_q == TMO_LIMIT) begin
          // Flag only; the transaction is never abandoned.
          err_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (grant_q == G_VID) begin
          if (!other_pending)              vid_cnt_d = '0;
          else if (vid_cnt_q != VID_LIMIT) vid_cnt_d = vid_cnt_q + CW'(1);
        end else begin
          vid_cnt_d = '0;
          rr_d      = (grant_q == G_CPU);
        end
      end
      default: state_d = SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= SYNC;
      grant_q    <= G_VID;
      rr_q       <= 1'b0;
      vid_cnt_q  <= '0;
      tmo_q      <= 8'h00;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= 8'h00;
      vid_dout_q <= 8'h00;
      cpu_dout_q <= 8'h00;
      dma_dout_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_q       <= rr_d;
      vid_cnt_q  <= vid_cnt_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
      busy_q     <= (state_d != IDLE);
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      vid_dout_q <= vid_dout_d;
      cpu_dout_q <= cpu_dout_d;
      dma_dout_q <= dma_dout_d;
    end
  end

  assign vid_ack  = (state_q == DONE) && (grant_q == G_VID);
  assign cpu_ack  = (state_q == DONE) && (grant_q == G_CPU);
  assign dma_ack  = (state_q == DONE) && (grant_q == G_DMA);
  assign vid_dout = vid_dout_q;
  assign cpu_dout = cpu_dout_q;
  assign dma_dout = dma_dout_q;
  assign mem_req  = mem_req_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
  assign busy     = busy_q;
  assign err      = err_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: table of single transactions plus
// hand-written arbitration, timeout and reset-recovery sequences.
module tb_sdram_port_arbiter;
  localparam int AW = 21;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          vid_req = 1'b0;
  logic [AW-1:0] vid_addr = '0;
  logic          vid_ack;
  logic [7:0]    vid_dout;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [7:0]    cpu_din = 8'h00;
  logic          cpu_ack;
  logic [7:0]    cpu_dout;
  logic          dma_req = 1'b0;
  logic          dma_we = 1'b0;
  logic [AW-1:0] dma_addr = '0;
  logic [7:0]    dma_din = 8'h00;
  logic          dma_ack;
  logic [7:0]    dma_dout;
  logic          mem_req;
  logic          mem_ack = 1'b0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_din;
  logic [7:0]    mem_dout = 8'h00;
  logic          busy;
  logic          err;

  always #5 clk = ~clk;

  sdram_port_arbiter #(.AW(AW), .VID_MAX(4), .TIMEOUT(255)) dut (
    .clk(clk), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_dout(vid_dout),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_din(dma_din),
    .dma_ack(dma_ack), .dma_dout(dma_dout),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout), .busy(busy), .err(err)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    din;
  } txn_t;

  typedef struct {
    int            id;        // 0=VID 1=CPU 2=DMA
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    din;
    logic [7:0]    exp_dout;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   vid_n = 0, cpu_n = 0, dma_n = 0;
  bit   ds_en = 1'b1;
  int   ds_lat = 6;
  int   ds_cnt = 0;
  logic last_req = 1'b0;
  txn_t tlog[$];
  int   glog[$];
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: log toggles, run the downstream echo model, retire acked requests.
  task automatic tick();
    txn_t t;
    @(posedge clk);
    #1;
    if (mem_req != last_req && !reset) begin
      t.we = mem_we; t.addr = mem_addr; t.din = mem_din;
      tlog.push_back(t);
    end
    last_req = mem_req;
    if (ds_en && (mem_req != mem_ack)) begin
      ds_cnt++;
      if (ds_cnt >= ds_lat) begin
        mem_dout = mem_addr[7:0];
        mem_ack  = mem_req;
        ds_cnt   = 0;
      end
    end
    if (vid_ack) begin glog.push_back(0); if (vid_n > 0) vid_n--; end
    if (cpu_ack) begin glog.push_back(1); if (cpu_n > 0) cpu_n--; end
    if (dma_ack) begin glog.push_back(2); if (dma_n > 0) dma_n--; end
    vid_req = (vid_n > 0);
    cpu_req = (cpu_n > 0);
    dma_req = (dma_n > 0);
  endtask

  task automatic sys_reset();
    reset = 1'b1;
    vid_n = 0; cpu_n = 0; dma_n = 0;
    vid_req = 1'b0; cpu_req = 1'b0; dma_req = 1'b0;
    mem_ack = 1'b0; ds_cnt = 0; ds_en = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while ((vid_n + cpu_n + dma_n) > 0 && n < budget) begin
      tick();
      n++;
    end
    check({name, "_timeout"}, vid_n + cpu_n + dma_n, 0);
    tick();
  endtask

  task automatic wait_toggle(input string name, output int lat);
    int start = tlog.size();
    lat = 0;
    while (tlog.size() == start && lat < 12) begin
      tick();
      lat++;
    end
    check({name, "_toggle_seen"}, tlog.size(), start + 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [7:0] dout;
    int exp_cd[8]   = '{1, 2, 1, 2, 1, 2, 1, 2};
    int exp_vs[10]  = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    int exp_all[3]  = '{0, 1, 2};

    vecs[0] = '{0, 1'b0, 21'h000C3,  8'h00, 8'hC3};
    vecs[1] = '{1, 1'b0, 21'h1FF5A,  8'h00, 8'h5A};
    vecs[2] = '{1, 1'b1, 21'h00100,  8'h3C, 8'h5A};
    vecs[3] = '{2, 1'b1, 21'h1FFFFF, 8'hFF, 8'h00};
    vecs[4] = '{2, 1'b0, 21'h00077,  8'h00, 8'h77};
    vecs[5] = '{0, 1'b0, 21'h00000,  8'h00, 8'h00};
    vecs[6] = '{2, 1'b1, 21'h00001,  8'h81, 8'h77};
    vecs[7] = '{1, 1'b0, 21'h0AB66,  8'h00, 8'h66};

    // Reset values
    reset = 1'b1;
    tick();
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_din", mem_din, 0);
    check("rst_acks", {vid_ack, cpu_ack, dma_ack}, 0);
    check("rst_douts", {vid_dout, cpu_dout, dma_dout}, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    reset = 1'b0;
    tick();
    check("idle_busy", busy, 0);

    // Single CPU write with a 6-cycle downstream echo
    tlog.delete(); glog.delete();
    cpu_we = 1'b1; cpu_addr = 21'h12345; cpu_din = 8'hA5; cpu_n = 1; cpu_req = 1'b1;
    wait_toggle("wr", lat);
    check("wr_latency", lat, 2);
    check("wr_mem_req", mem_req, 1);
    check("wr_mem_we", mem_we, 1);
    check("wr_mem_addr", mem_addr, 21'h12345);
    check("wr_mem_din", mem_din, 8'hA5);
    check("wr_busy", busy, 1);
    wait_done(40, "wr");
    check("wr_ack_count", glog.size(), 1);
    check("wr_cpu_dout", cpu_dout, 8'h00);
    check("wr_busy_after", busy, 0);

    // Table of isolated transactions; inputs are scrambled after the grant cycle
    foreach (vecs[i]) begin
      tlog.delete(); glog.delete();
      case (vecs[i].id)
        0: begin vid_addr = vecs[i].addr; vid_n = 1; vid_req = 1'b1; end
        1: begin cpu_we = vecs[i].we; cpu_addr = vecs[i].addr; cpu_din = vecs[i].din;
                 cpu_n = 1; cpu_req = 1'b1; end
        default: begin dma_we = vecs[i].we; dma_addr = vecs[i].addr; dma_din = vecs[i].din;
                 dma_n = 1; dma_req = 1'b1; end
      endcase
      tick();
      vid_addr = ~vecs[i].addr;
      cpu_addr = ~vecs[i].addr; cpu_din = ~vecs[i].din; cpu_we = ~vecs[i].we;
      dma_addr = ~vecs[i].addr; dma_din = ~vecs[i].din; dma_we = ~vecs[i].we;
      wait_done(60, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_acks", i), glog.size(), 1);
      if (glog.size() == 1) check($sformatf("vec%0d_grant", i), glog[0], vecs[i].id);
      check($sformatf("vec%0d_txns", i), tlog.size(), 1);
      if (tlog.size() == 1) begin
        check($sformatf("vec%0d_addr", i), tlog[0].addr, vecs[i].addr);
        check($sformatf("vec%0d_we", i), tlog[0].we, vecs[i].we);
        if (vecs[i].we) check($sformatf("vec%0d_din", i), tlog[0].din, vecs[i].din);
      end
      case (vecs[i].id)
        0:       dout = vid_dout;
        1:       dout = cpu_dout;
        default: dout = dma_dout;
      endcase
      check($sformatf("vec%0d_dout", i), dout, vecs[i].exp_dout);
    end

    // CPU and DMA contending: strict alternation starting with CPU
    sys_reset();
    glog.delete();
    cpu_we = 1'b0; dma_we = 1'b0; cpu_addr = 21'h00011; dma_addr = 21'h00022;
    cpu_n = 4; dma_n = 4; cpu_req = 1'b1; dma_req = 1'b1;
    wait_done(300, "rr");
    check("rr_count", glog.size(), 8);
    for (int i = 0; i < 8 && i < glog.size(); i++)
      check($sformatf("rr_grant%0d", i), glog[i], exp_cd[i]);
    check("rr_cpu_dout", cpu_dout, 8'h11);
    check("rr_dma_dout", dma_dout, 8'h22);

    // VID streaming with CPU pending: CPU gets in after every 4 VID grants
    glog.delete();
    vid_addr = 21'h000C3; vid_n = 8; cpu_n = 2; vid_req = 1'b1; cpu_req = 1'b1;
    wait_done(400, "vs");
    check("vs_count", glog.size(), 10);
    for (int i = 0; i < 10 && i < glog.size(); i++)
      check($sformatf("vs_grant%0d", i), glog[i], exp_vs[i]);

    // All three at once from reset: VID, then CPU (rr untouched), then DMA
    sys_reset();
    glog.delete();
    vid_n = 1; cpu_n = 1; dma_n = 1; vid_req = 1'b1; cpu_req = 1'b1; dma_req = 1'b1;
    wait_done(200, "all3");
    check("all3_count", glog.size(), 3);
    for (int i = 0; i < 3 && i < glog.size(); i++)
      check($sformatf("all3_grant%0d", i), glog[i], exp_all[i]);

    // Downstream never answers: err after exactly TIMEOUT+1 cycles in WAIT
    ds_en = 1'b0; glog.delete();
    cpu_we = 1'b0; cpu_addr = 21'h00033; cpu_n = 1; cpu_req = 1'b1;
    wait_toggle("tmo", lat);
    repeat (255) tick();
    check("tmo_err_before", err, 0);
    tick();
    check("tmo_err_at", err, 1);
    repeat (20) tick();
    check("tmo_err_sticky", err, 1);
    check("tmo_busy", busy, 1);
    check("tmo_no_ack", glog.size(), 0);

    // Reset while a toggle is outstanding, then recovery
    sys_reset();
    check("rst2_err_clear", err, 0);
    ds_en = 1'b0;
    cpu_we = 1'b0; cpu_addr = 21'h00042; cpu_n = 1; cpu_req = 1'b1;
    wait_toggle("mid", lat);
    check("mid_mem_req_pending", mem_req, 1);
    reset = 1'b1; cpu_n = 0; cpu_req = 1'b0;
    tick();
    check("mid_rst_mem_req", mem_req, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ack", cpu_ack, 0);
    reset = 1'b0; mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("sync_hold%0d_mem_req", i), mem_req, 0);
      check($sformatf("sync_hold%0d_busy", i), busy, 1);
    end
    tlog.delete(); glog.delete();
    cpu_n = 1; cpu_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("sync_noissue%0d", i), mem_req, 0);
    end
    mem_ack = 1'b0; ds_en = 1'b1; ds_cnt = 0;
    wait_done(60, "recover");
    check("recover_acks", glog.size(), 1);
    if (glog.size() == 1) check("recover_grant", glog[0], 1);
    check("recover_txns", tlog.size(), 1);
    check("recover_mem_req", mem_req, 1);
    check("recover_cpu_dout", cpu_dout, 8'h42);
    check("recover_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
